scroll_display_sched: RTL and testbench

//  Sequencer for the 4-digit seven-segment scrolling display. Holds a loadable message of up
//  to MSG_MAX symbol codes. Steps a 4-digit window across the message at the scroll rate.

---
 rtl/scroll_pkg.sv | 20 ++
 rtl/tick_div.sv | 27 ++
 rtl/scroll_display_sched.sv | 201 ++++++++++++++++++++
 tb/tb_scroll_display_sched.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scroll_pkg.sv
// Shared types and constants for the scrolling seven-segment display sequencer.
package scroll_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        HOLD
    } state_t;

    localparam int         NDIG      = 4;
    localparam int         BLANK_SYM = 0;
    localparam logic [3:0] EN_OFF    = 4'b1111;

    // Active-low one-cold anode pattern for digit d (d=0 is the rightmost digit).
    function automatic logic [NDIG-1:0] digit_en(input logic [1:0] d);
        return ~(NDIG'(1) << d);
    endfunction

endpackage

// File: rtl/tick_div.sv
// Modulo-DIV cycle counter with synchronous clear; tick is high during the terminal count.
module tick_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = $clog2(DIV);

    logic [W-1:0] cnt_q;

    assign tick = (cnt_q == W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/scroll_display_sched.sv
// Message buffer, scroll window and digit multiplexer for the 4-digit scrolling display.
// Optional end-of-message hold is enabled by defining SCROLL_HOLD_EN.
module scroll_display_sched
    import scroll_pkg::*;
#(
    parameter int REFRESH_DIV = 100_000,
    parameter int SCROLL_DIV  = 100_000_000,
    parameter int MSG_MAX     = 16,
    parameter int SYM_W       = 3,
    parameter int HOLD_STEPS  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [SYM_W-1:0] wr_sym,
    input  logic             wr_last,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic [SYM_W-1:0] sym_out,
    output logic [3:0]       en,
    output logic             step_pulse,
    output logic             wrap_pulse
);

    localparam int PW = $clog2(MSG_MAX + 4);
    localparam int AW = $clog2(MSG_MAX);
    localparam int LW = $clog2(MSG_MAX + 1);

    if (REFRESH_DIV < 2 || SCROLL_DIV < 2 || HOLD_STEPS < 1) begin : g_param_check
        $error("scroll_display_sched: REFRESH_DIV/SCROLL_DIV must be >=2, HOLD_STEPS >=1");
    end

    state_t           state_q;
    logic [LW-1:0]    len_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [PW-1:0]    pos_q;
    logic [1:0]       dig_q;
    logic             busy_q;
    logic             wr_ready_q;
    logic             step_q;
    logic             wrap_q;
    logic [3:0]       en_q;
    logic [SYM_W-1:0] sym_q;
    logic [SYM_W-1:0] msg_mem [MSG_MAX];

    logic             running;
    logic             r_tick;
    logic             s_tick;
    logic             wr_acc;
    logic [AW-1:0]    eff_ptr;
    logic             wr_close;
    logic             start_go;
    logic             step_ev;
    logic             at_end;
    logic [PW-1:0]    pos_d;
    logic [PW-1:0]    diff;
    logic             in_win;
    logic [SYM_W-1:0] sym_d;
    logic             show_d;

    assign running  = (state_q == RUN) || (state_q == HOLD);
    assign wr_acc   = wr_valid && wr_ready_q;
    // The first write of a message always lands in slot 0, whatever wr_ptr held before.
    assign eff_ptr  = (state_q == LOAD) ? wr_ptr_q : '0;
    assign wr_close = wr_last || (eff_ptr == AW'(MSG_MAX - 1));
    assign start_go = (state_q == IDLE) && start && !stop && !wr_acc && (len_q != '0);
    assign step_ev  = s_tick && running && !stop;
    assign at_end   = (pos_q == PW'(len_q) + PW'(3));
    assign pos_d    = at_end ? '0 : pos_q + PW'(1);

    // Digit d shows the symbol d places behind the window head; outside the message it is blank.
    assign diff   = pos_q - PW'(dig_q);
    assign in_win = (pos_q >= PW'(dig_q)) && (diff < PW'(len_q));
    assign sym_d  = in_win ? msg_mem[AW'(diff)] : SYM_W'(BLANK_SYM);
    assign show_d = (running && !stop) || start_go;

`ifdef SCROLL_HOLD_EN
    localparam int HW = $clog2(HOLD_STEPS + 1);
    logic [HW-1:0] hold_cnt_q;
    logic          hold_hit;
    assign hold_hit = (pos_d == PW'(len_q) - PW'(1));
`endif

    tick_div #(.DIV(REFRESH_DIV)) u_refresh_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (!running),
        .tick (r_tick)
    );

    tick_div #(.DIV(SCROLL_DIV)) u_scroll_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (!running),
        .tick (s_tick)
    );

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            msg_mem[eff_ptr] <= wr_sym;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            wr_ptr_q   <= '0;
            pos_q      <= '0;
            busy_q     <= 1'b0;
            wr_ready_q <= 1'b1;
            step_q     <= 1'b0;
            wrap_q     <= 1'b0;
`ifdef SCROLL_HOLD_EN
            hold_cnt_q <= '0;
`endif
        end else begin
            step_q <= step_ev;
            wrap_q <= 1'b0;
            if (wr_acc) begin
                if (wr_close) begin
                    state_q  <= IDLE;
                    len_q    <= LW'(eff_ptr) + LW'(1);
                    wr_ptr_q <= '0;
                end else begin
                    state_q  <= LOAD;
                    len_q    <= '0;
                    wr_ptr_q <= eff_ptr + AW'(1);
                end
            end else if (start_go) begin
                state_q    <= RUN;
                busy_q     <= 1'b1;
                wr_ready_q <= 1'b0;
                pos_q      <= '0;
`ifdef SCROLL_HOLD_EN
                hold_cnt_q <= '0;
                if (len_q == LW'(1)) begin
                    state_q <= HOLD;
                end
`endif
            end else if (running && stop) begin
                state_q    <= IDLE;
                busy_q     <= 1'b0;
                wr_ready_q <= 1'b1;
                pos_q      <= '0;
            end else if (step_ev) begin
                case (state_q)
                    RUN: begin
                        pos_q  <= pos_d;
                        wrap_q <= at_end;
`ifdef SCROLL_HOLD_EN
                        if (hold_hit) begin
                            state_q    <= HOLD;
                            hold_cnt_q <= '0;
                        end
`endif
                    end
`ifdef SCROLL_HOLD_EN
                    HOLD: begin
                        if (hold_cnt_q == HW'(HOLD_STEPS - 1)) begin
                            state_q <= RUN;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + HW'(1);
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    // Anode and symbol are registered together so a digit never shows its neighbour's code.
    always_ff @(posedge clk) begin
        if (!rst) begin
            en_q  <= EN_OFF;
            sym_q <= SYM_W'(BLANK_SYM);
            dig_q <= '0;
        end else if (show_d) begin
            en_q  <= digit_en(dig_q);
            sym_q <= sym_d;
            if (running && r_tick) begin
                dig_q <= dig_q + 2'd1;
            end
        end else begin
            en_q  <= EN_OFF;
            sym_q <= SYM_W'(BLANK_SYM);
            dig_q <= '0;
        end
    end

    assign wr_ready   = wr_ready_q;
    assign busy       = busy_q;
    assign sym_out    = sym_q;
    assign en         = en_q;
    assign step_pulse = step_q;
    assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_scroll_display_sched.sv
// Directed bench for scroll_display_sched with REFRESH_DIV=4, SCROLL_DIV=32, MSG_MAX=16.
module tb_scroll_display_sched;

    localparam int SDIV = 32;
`ifdef SCROLL_HOLD_EN
    localparam int HOLD_X = 2;
`else
    localparam int HOLD_X = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_sym;
    logic       wr_last;
    logic       start;
    logic       stop;
    logic       busy;
    logic [2:0] sym_out;
    logic [3:0] en;
    logic       step_pulse;
    logic       wrap_pulse;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_cnt, step_cnt, wrap_cnt, wrap_step, wrap_cyc;
    logic wrap_with_step;

    always #5 clk = ~clk;

    scroll_display_sched #(
        .REFRESH_DIV (4),
        .SCROLL_DIV  (SDIV),
        .MSG_MAX     (16),
        .SYM_W       (3),
        .HOLD_STEPS  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_sym     (wr_sym),
        .wr_last    (wr_last),
        .start      (start),
        .stop       (stop),
        .busy       (busy),
        .sym_out    (sym_out),
        .en         (en),
        .step_pulse (step_pulse),
        .wrap_pulse (wrap_pulse)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-22s observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to the next falling edge and tally the pulses seen there.
    task automatic cyc();
        @(negedge clk);
        cyc_cnt++;
        if (step_pulse) step_cnt++;
        if (wrap_pulse) begin
            wrap_cnt++;
            wrap_step      = step_cnt;
            wrap_cyc       = cyc_cnt;
            wrap_with_step = step_pulse;
        end
    endtask

    task automatic write_sym(input logic [2:0] s, input logic last);
        wr_valid = 1'b1;
        wr_sym   = s;
        wr_last  = last;
        cyc();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        cyc();
        start     = 1'b0;
        cyc_cnt   = 0;
        step_cnt  = 0;
        wrap_cnt  = 0;
        wrap_step = -1;
        wrap_cyc  = -1;
        wrap_with_step = 1'b0;
    endtask

    task automatic stop_run();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    task automatic wait_steps(input string tag, input int n);
        int g = 0;
        while (step_cnt < n && g < 2000) begin
            cyc();
            g++;
        end
        check(tag, step_cnt, n);
    endtask

    task automatic wait_wrap(input string tag, input int exp_steps);
        int g = 0;
        while (wrap_cnt == 0 && g < 2000) begin
            cyc();
            g++;
        end
        check({tag, "_wrap_steps"}, wrap_step, exp_steps);
        check({tag, "_wrap_cyc"}, wrap_cyc, exp_steps * SDIV);
        check({tag, "_wrap_w_step"}, wrap_with_step, 1'b1);
    endtask

    // Let one registered update pass, then find the given anode slot and check its symbol.
    task automatic look(input string tag, input logic [3:0] pat, input logic [2:0] exp_sym);
        int g = 0;
        cyc();
        while (en !== pat && g < 16) begin
            cyc();
            g++;
        end
        check({tag, "_en"}, en, pat);
        check({tag, "_sym"}, sym_out, exp_sym);
    endtask

    initial begin
        rst      = 1'b0;
        wr_valid = 1'b0;
        wr_sym   = '0;
        wr_last  = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        cyc_cnt  = 0;
        step_cnt = 0;
        wrap_cnt = 0;

        // Reset state
        cyc();
        cyc();
        check("rst_en", en, 4'b1111);
        check("rst_sym", sym_out, 3'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_ready", wr_ready, 1'b1);
        check("rst_step", step_pulse, 1'b0);
        check("rst_wrap", wrap_pulse, 1'b0);
        rst = 1'b1;
        cyc();

        // Six-symbol message
        for (int i = 1; i <= 6; i++) begin
            write_sym(3'(i), i == 6);
        end
        check("msg6_wr_ready", wr_ready, 1'b1);
        start_run();
        check("msg6_first_en", en, 4'b1110);
        check("msg6_first_sym", sym_out, 3'd1);
        check("msg6_busy", busy, 1'b1);
        check("msg6_run_wr_ready", wr_ready, 1'b0);
        wait_steps("msg6_3steps", 3);
        check("msg6_3steps_cyc", cyc_cnt, 3 * SDIV);
        look("msg6_p3_d3", 4'b0111, 3'd1);
        look("msg6_p3_d0", 4'b1110, 3'd4);
        wait_wrap("msg6", 10);
        stop_run();
        check("msg6_stop_en", en, 4'b1111);
        check("msg6_stop_busy", busy, 1'b0);

        // Sixteen symbols without wr_last: auto-close
        wr_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_sym = 3'((i % 7) + 1);
            cyc();
        end
        wr_valid = 1'b0;
        check("auto_wr_ready", wr_ready, 1'b1);
        start_run();
        check("auto_busy", busy, 1'b1);
        check("auto_first_sym", sym_out, 3'd1);
        wait_wrap("auto", 20);
        stop_run();

        // 17th write opens a new message; start in LOAD is ignored
        write_sym(3'd5, 1'b0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("load_start_ignored", busy, 1'b0);
        check("load_wr_ready", wr_ready, 1'b1);
        write_sym(3'd6, 1'b1);
        start_run();
        check("msg2_first_en", en, 4'b1110);
        check("msg2_first_sym", sym_out, 3'd5);
        wait_wrap("msg2", 6);

        // start and stop together while running
        start = 1'b1;
        stop  = 1'b1;
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        check("ss_en", en, 4'b1111);
        check("ss_sym", sym_out, 3'd0);
        check("ss_busy", busy, 1'b0);
        check("ss_wr_ready", wr_ready, 1'b1);

        // Three-symbol message, end-of-message hold when enabled
        write_sym(3'd1, 1'b0);
        write_sym(3'd2, 1'b0);
        write_sym(3'd3, 1'b1);
        start_run();
        wait_steps("len3_2steps", 2);
        look("len3_s2", 4'b1110, 3'd3);
        wait_steps("len3_4steps", 4);
        look("len3_s4", 4'b1110, (HOLD_X != 0) ? 3'd3 : 3'd0);
        wait_wrap("len3", 7 + HOLD_X);

        // Reset in the middle of a run discards the message
        cyc();
        cyc();
        check("mid_busy_before", busy, 1'b1);
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        check("mid_rst_en", en, 4'b1111);
        check("mid_rst_sym", sym_out, 3'd0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_wr_ready", wr_ready, 1'b1);
        check("mid_rst_step", step_pulse, 1'b0);
        check("mid_rst_wrap", wrap_pulse, 1'b0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("mid_start_busy", busy, 1'b0);
        check("mid_start_en", en, 4'b1111);
        cyc();
        check("mid_start_busy2", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
